ps_setpoint_coef_scheduler: RTL and testbench

- Sits between the CPU register bus and the power-supply setpoint calculator's coefficient write port: gain, FFB clip, PS offset and PS clip tables.
- CPU coefficient writes are queued. A commit strobe releases the queued batch, which drains only while the setpoint pipeline is idle, so that no computation burst sees a half-updated coefficient set.
- Also forwards the FIR-result toggle to the calculator. The toggle is delayed while a batch drain is in progress.

---
 rtl/ps_setpoint_coef_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_ps_setpoint_coef_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_setpoint_coef_scheduler.sv
// ps_setpoint_coef_scheduler
// Commit-gated coefficient write queue with FIR toggle forwarding.
module ps_setpoint_coef_scheduler #(
  parameter int RESULT_COUNT       = 24,
  parameter int RESULT_COUNT_WIDTH = 5,
  parameter int DBUS_WIDTH         = 32,
  parameter int QUEUE_DEPTH        = 16,
  parameter int BUSY_CYCLES        = 40
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpuWriteStrobe,
  input  logic [1:0]                    cpuSelect,
  input  logic [RESULT_COUNT_WIDTH-1:0] cpuAddress,
  input  logic [DBUS_WIDTH-1:0]         cpuData,
  input  logic                          cpuCommit,
  input  logic                          cpuClearStatus,
  input  logic                          dinToggleIn,
  output logic                          dinToggleOut,
  output logic                          gainWriteStrobe,
  output logic                          ffbClipWriteStrobe,
  output logic                          psOffsetWriteStrobe,
  output logic                          psClipWriteStrobe,
  output logic [RESULT_COUNT_WIDTH-1:0] writeAddress,
  output logic [DBUS_WIDTH-1:0]         writeData,
  output logic [7:0]                    status,
  output logic [$clog2(QUEUE_DEPTH):0]  queueCount
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int QW = AW + 1;
  localparam int CW = $clog2(BUSY_CYCLES);
  localparam int EW = 2 + RESULT_COUNT_WIDTH + DBUS_WIDTH;

  if (BUSY_CYCLES < RESULT_COUNT + 8) begin : g_bad_busy
    $error("BUSY_CYCLES shorter than a computation burst");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [EW-1:0]           mem_q [QUEUE_DEPTH];
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [AW-1:0]           rptr_q, rptr_d;
  logic [QW-1:0]           count_q, count_d;
  logic [QW-1:0]           committed_q, committed_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    track_q, track_d;
  logic                    tout_q, tout_d;
  logic                    held_q, held_d;
  logic                    ovf_q, ovf_d;
  logic                    lost_q, lost_d;
  logic                    lost_set;
  logic [3:0]              strb_q, strb_d;
  logic [RESULT_COUNT_WIDTH-1:0] addr_q, addr_d;
  logic [DBUS_WIDTH-1:0]   data_q, data_d;

  logic                    full, push, pop, edge_in;
  logic [1:0]              head_sel;
  logic [RESULT_COUNT_WIDTH-1:0] head_addr;
  logic [DBUS_WIDTH-1:0]   head_data;

  assign full    = (count_q == QW'(QUEUE_DEPTH));
  assign push    = cpuWriteStrobe && !full;
  assign pop     = (state_q == DRAIN) && (committed_q != '0);
  assign edge_in = dinToggleIn ^ track_q;
  assign {head_sel, head_addr, head_data} = mem_q[rptr_q];

  assign wptr_d  = wptr_q + AW'(push);
  assign rptr_d  = rptr_q + AW'(pop);
  assign count_d = count_q + QW'(push) - QW'(pop);
  assign ovf_d   = (cpuWriteStrobe && full) || (ovf_q && !cpuClearStatus);
  assign lost_d  = lost_set || (lost_q && !cpuClearStatus);

  // Queue storage; occupancy is tracked by the pointers, not the data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {cpuSelect, cpuAddress, cpuData};
    end
  end

  // Scheduler: toggle forwarding has priority, drains run only when idle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    track_d     = track_q;
    tout_d      = tout_q;
    held_d      = held_q;
    lost_set    = 1'b0;
    strb_d      = '0;
    addr_d      = addr_q;
    data_d      = data_q;
    committed_d = committed_q - QW'(pop);
    if (cpuCommit) begin
      committed_d = count_d;
    end
    unique case (state_q)
      IDLE: begin
        if (held_q || edge_in) begin
          track_d = dinToggleIn;
          held_d  = 1'b0;
          if (held_q && edge_in) begin
            lost_set = 1'b1;
          end else begin
            tout_d  = ~tout_q;
            state_d = BUSY;
            cnt_d   = CW'(BUSY_CYCLES - 1);
          end
        end else if (committed_q != '0) begin
          state_d = DRAIN;
        end
      end
      BUSY: begin
        if (edge_in) begin
          track_d = dinToggleIn;
          tout_d  = ~tout_q;
          cnt_d   = CW'(BUSY_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        if (pop) begin
          strb_d[head_sel] = 1'b1;
          addr_d = head_addr;
          data_d = head_data;
        end
        if (edge_in) begin
          track_d = dinToggleIn;
          held_d  = ~held_q;
          if (held_q) begin
            lost_set = 1'b1;
          end
        end
        if (committed_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      committed_q <= '0;
      cnt_q       <= '0;
      track_q     <= 1'b0;
      tout_q      <= 1'b0;
      held_q      <= 1'b0;
      ovf_q       <= 1'b0;
      lost_q      <= 1'b0;
      strb_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      committed_q <= committed_d;
      cnt_q       <= cnt_d;
      track_q     <= track_d;
      tout_q      <= tout_d;
      held_q      <= held_d;
      ovf_q       <= ovf_d;
      lost_q      <= lost_d;
      strb_q      <= strb_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign dinToggleOut        = tout_q;
  assign gainWriteStrobe     = strb_q[0];
  assign ffbClipWriteStrobe  = strb_q[1];
  assign psOffsetWriteStrobe = strb_q[2];
  assign psClipWriteStrobe   = strb_q[3];
  assign writeAddress        = addr_q;
  assign writeData           = data_q;
  assign queueCount          = count_q;
  assign status = {3'b000, lost_q, ovf_q, state_q == DRAIN,
                   committed_q != '0, full};

endmodule

// File: tb/tb_ps_setpoint_coef_scheduler.sv
// tb_ps_setpoint_coef_scheduler
// Directed scenarios plus random traffic against a queue-based model.
module tb_ps_setpoint_coef_scheduler;

  localparam int RC = 24;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int QD = 16;
  localparam int BC = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    sel = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          commit = 1'b0;
  logic          clr = 1'b0;
  logic          din = 1'b0;
  logic          tout, sg, sf, so, sc;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [7:0]    status;
  logic [4:0]    qcnt;

  always #5 clk = ~clk;

  ps_setpoint_coef_scheduler #(
    .RESULT_COUNT(RC),
    .RESULT_COUNT_WIDTH(AW),
    .DBUS_WIDTH(DW),
    .QUEUE_DEPTH(QD),
    .BUSY_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpuWriteStrobe(we),
    .cpuSelect(sel),
    .cpuAddress(addr),
    .cpuData(data),
    .cpuCommit(commit),
    .cpuClearStatus(clr),
    .dinToggleIn(din),
    .dinToggleOut(tout),
    .gainWriteStrobe(sg),
    .ffbClipWriteStrobe(sf),
    .psOffsetWriteStrobe(so),
    .psClipWriteStrobe(sc),
    .writeAddress(waddr),
    .writeData(wdata),
    .status(status),
    .queueCount(qcnt)
  );

  typedef struct packed {
    logic [1:0]    s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  int            m_commit;
  int            m_mode;
  int            m_left;
  bit            m_track, m_tout, m_held, m_ovf, m_lost;
  logic [3:0]    m_strb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            n_vec = 0;
  int            n_bad = 0;

  function automatic void m_reset();
    mq.delete();
    m_commit = 0;
    m_mode = 0;
    m_left = 0;
    m_track = 0;
    m_tout = 0;
    m_held = 0;
    m_ovf = 0;
    m_lost = 0;
    m_strb = '0;
    m_addr = '0;
    m_data = '0;
  endfunction

  // One clock of the scheduler's rules, using the inputs at that edge.
  function automatic void m_step();
    bit   ed;
    bit   full;
    bit   popping;
    bit   lost;
    int   mode_n;
    int   commit_n;
    ent_t e;
    ed = (din != m_track);
    full = (mq.size() == QD);
    popping = (m_mode == 2) && (m_commit > 0);
    lost = 0;
    mode_n = m_mode;
    m_strb = '0;
    if (popping) begin
      e = mq.pop_front();
      m_strb[e.s] = 1'b1;
      m_addr = e.a;
      m_data = e.d;
    end
    if (we && !full) mq.push_back('{sel, addr, data});
    m_ovf = (we && full) || (m_ovf && !clr);
    commit_n = commit ? mq.size() : m_commit - int'(popping);
    case (m_mode)
      0: begin
        if (m_held || ed) begin
          m_track = din;
          if (m_held && ed) lost = 1;
          else begin
            m_tout = !m_tout;
            mode_n = 1;
            m_left = BC;
          end
          m_held = 0;
        end else if (m_commit > 0) mode_n = 2;
      end
      1: begin
        if (ed) begin
          m_track = din;
          m_tout = !m_tout;
          m_left = BC;
        end else begin
          m_left--;
          if (m_left == 0) mode_n = 0;
        end
      end
      default: begin
        if (ed) begin
          m_track = din;
          if (m_held) lost = 1;
          m_held = !m_held;
        end
        if (commit_n == 0) mode_n = 0;
      end
    endcase
    m_lost = lost || (m_lost && !clr);
    m_commit = commit_n;
    m_mode = mode_n;
  endfunction

  task automatic check(input string tag);
    logic [7:0] exp_st;
    exp_st = {3'b000, m_lost, m_ovf, m_mode == 2, m_commit > 0,
              mq.size() == QD};
    n_vec++;
    assert ({sc, so, sf, sg, waddr, wdata} === {m_strb, m_addr, m_data})
    else begin
      n_bad++;
      $error("FAIL %s wrport: got %h/%h/%h exp %h/%h/%h", tag,
             {sc, so, sf, sg}, waddr, wdata, m_strb, m_addr, m_data);
    end
    n_vec++;
    assert (tout === m_tout) else begin
      n_bad++;
      $error("FAIL %s toggle: got %b exp %b", tag, tout, m_tout);
    end
    n_vec++;
    assert ({status, qcnt} === {exp_st, 5'(mq.size())}) else begin
      n_bad++;
      $error("FAIL %s status/count: got %h/%0d exp %h/%0d", tag,
             status, qcnt, exp_st, mq.size());
    end
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit w, input logic [1:0] s,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit c, input bit cl, input bit t);
    @(negedge clk);
    we = w;
    sel = s;
    addr = a;
    data = d;
    commit = c;
    clr = cl;
    if (t) din = ~din;
    @(posedge clk);
    m_step();
    #1;
    check("cycle");
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 2'd0, '0, '0, 0, 0, 0);
  endtask

  task automatic rnd_wr();
    cyc(1, 2'($urandom), AW'($urandom_range(RC - 1)), $urandom, 0, 0, 0);
  endtask

  int   ns;
  int   last_s;
  int   tch;
  logic t_before;

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check("reset");
    rst_n = 1'b1;
    idle(5);

    // idle forwarding
    cyc(0, 2'd0, '0, '0, 0, 0, 1);
    chk_eq("fwd_latency", 32'(tout), 32'd1);
    idle(45);

    // basic drain
    cyc(1, 2'd0, 5'd2, 32'h100, 0, 0, 0);
    cyc(1, 2'd1, 5'd5, 32'h2000, 0, 0, 0);
    cyc(1, 2'd3, 5'd23, 32'h7FFFFFF, 0, 0, 0);
    cyc(0, 2'd0, '0, '0, 1, 0, 0);
    idle(8);
    chk_eq("drain_empty", 32'(qcnt), 32'd0);

    // commit while busy
    cyc(0, 2'd0, '0, '0, 0, 0, 1);
    repeat (4) rnd_wr();
    cyc(0, 2'd0, '0, '0, 1, 0, 0);
    idle(50);

    // single toggle held during a full drain
    repeat (16) rnd_wr();
    cyc(0, 2'd0, '0, '0, 1, 0, 0);
    ns = 0;
    last_s = -1;
    tch = -1;
    for (int i = 0; i < 40; i++) begin
      t_before = tout;
      cyc(0, 2'd0, '0, '0, 0, 0, ns == 3 && tch < 0 && last_s >= 0 &&
          i == last_s + 1);
      if (m_strb != 0) begin
        ns++;
        last_s = i;
      end
      if (tout != t_before && tch < 0) tch = i;
    end
    chk_eq("held_strobes", 32'(ns), 32'd16);
    chk_eq("held_delay", 32'(tch - last_s), 32'd1);
    idle(45);

    // two toggles during drain cancel
    repeat (16) rnd_wr();
    cyc(0, 2'd0, '0, '0, 1, 0, 0);
    t_before = tout;
    ns = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 2'd0, '0, '0, 0, 0, i == 4 || i == 8);
      if (m_strb != 0) ns++;
    end
    chk_eq("lost_strobes", 32'(ns), 32'd16);
    chk_eq("lost_no_toggle", 32'(tout), 32'(t_before));
    chk_eq("lost_flag", 32'(status[4]), 32'd1);
    cyc(0, 2'd0, '0, '0, 0, 1, 0);
    chk_eq("lost_clear", 32'(status[4]), 32'd0);

    // overflow and partial commit
    repeat (17) rnd_wr();
    chk_eq("ovf_count", 32'(qcnt), 32'd16);
    chk_eq("ovf_flag", 32'(status[3]), 32'd1);
    chk_eq("ovf_full", 32'(status[0]), 32'd1);
    cyc(0, 2'd0, '0, '0, 1, 0, 0);
    ns = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2 || i == 3) rnd_wr();
      else idle(1);
      if (m_strb != 0) ns++;
    end
    chk_eq("partial_strobes", 32'(ns), 32'd16);
    chk_eq("partial_left", 32'(qcnt), 32'd2);
    cyc(0, 2'd0, '0, '0, 1, 1, 0);
    idle(10);
    chk_eq("partial_done", 32'(qcnt), 32'd0);

    // reset in the middle of a drain
    repeat (10) rnd_wr();
    cyc(0, 2'd0, '0, '0, 1, 0, 0);
    ns = 0;
    for (int i = 0; i < 30 && ns < 5; i++) begin
      idle(1);
      if (m_strb != 0) ns++;
    end
    chk_eq("pre_reset_strobes", 32'(ns), 32'd5);
    #1 rst_n = 1'b0;
    din = 1'b0;
    #1 m_reset();
    check("reset_mid");
    chk_eq("reset_mid_count", 32'(qcnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if ({sc, so, sf, sg} != 4'b0) ns++;
    end
    chk_eq("post_reset_strobes", 32'(ns), 32'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(2) == 0, 2'($urandom),
          AW'($urandom_range(RC - 1)), $urandom,
          $urandom_range(15) == 0, $urandom_range(31) == 0,
          $urandom_range(19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
